// File: rtl/conv_bus_arbiter.sv
// conv_bus_arbiter: shares one data/addr bus between n_units conv units.
// Grants one unit in one direction at a time and holds it until the burst ends.
// Winners are picked round-robin; inside a unit a write beats a read.
//
// Optional feature: define CONV_ARB_TIMEOUT_EN to add a per-grant watchdog
// and the sticky timeout_err output.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rd_req, wr_req        per-unit read / write burst requests
//   link_read/link_write  one-hot path enables to the granted unit
//   rvalid, rlast         read beat valid / last read beat
//   wready, wuser_last    write beat accepted / last write beat
//   busy                  a grant is active
//   grant_id, grant_wr    granted unit (0 when idle) and direction (1 = write)
//   timeout_err           sticky watchdog flag (CONV_ARB_TIMEOUT_EN only)
module conv_bus_arbiter #(
    parameter int unsigned n_units        = 4,
    parameter int unsigned id_width       = 2,
    parameter int unsigned turnaround     = 1,
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [n_units-1:0]  rd_req,
    input  logic [n_units-1:0]  wr_req,
    output logic [n_units-1:0]  link_read,
    output logic [n_units-1:0]  link_write,
    input  logic                rvalid,
    input  logic                rlast,
    input  logic                wready,
    input  logic                wuser_last,
    output logic                busy,
    output logic [id_width-1:0] grant_id,
    output logic                grant_wr
`ifdef CONV_ARB_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    typedef enum logic [1:0] {StIdle, StGrantRd, StGrantWr, StGap} state_e;

    localparam int unsigned GapW = 2;

    state_e              state_q, state_d;
    logic [id_width-1:0] winner_q, winner_d;
    logic [id_width-1:0] rr_ptr_q, rr_ptr_d;
    logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;

    logic                pick_found;
    logic [id_width-1:0] pick_id;
    logic                pick_wr;
    int unsigned         idx;

    logic                burst_done;
    logic                release_grant;
    logic [id_width-1:0] next_ptr;

    // Round-robin search starting at rr_ptr, wrapping at n_units-1.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_wr    = 1'b0;
        idx        = 0;
        for (int i = 0; i < int'(n_units); i++) begin
            idx = (int'(rr_ptr_q) + i) % n_units;
            if (!pick_found && (rd_req[idx] || wr_req[idx])) begin
                pick_found = 1'b1;
                pick_id    = id_width'(idx);
                pick_wr    = wr_req[idx];
            end
        end
    end

    assign burst_done = ((state_q == StGrantRd) && rvalid && rlast) ||
                        ((state_q == StGrantWr) && wready && wuser_last);

    assign next_ptr = (winner_q == id_width'(n_units - 1)) ? '0 : winner_q + 1'b1;

`ifdef CONV_ARB_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(timeout_cycles + 1);

    logic [ToW-1:0] to_cnt_q;
    logic           timeout_hit;
    logic           timeout_err_q;

    assign timeout_hit = ((state_q == StGrantRd) || (state_q == StGrantWr)) &&
                         !burst_done && (to_cnt_q == ToW'(timeout_cycles - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                to_cnt_q <= '0;
            end else if ((state_q == StGrantRd) || (state_q == StGrantWr)) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err   = timeout_err_q;
    assign release_grant = burst_done || timeout_hit;
`else
    assign release_grant = burst_done;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            winner_q  <= '0;
            rr_ptr_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // The IDLE arbitration cycle is itself a dead bus cycle, so GAP only adds
    // turnaround-1 further cycles; total dead cycles = max(turnaround, 1).
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        rr_ptr_d  = rr_ptr_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d  = pick_wr ? StGrantWr : StGrantRd;
                    winner_d = pick_id;
                end
            end
            StGrantRd, StGrantWr: begin
                if (release_grant) begin
                    rr_ptr_d  = next_ptr;
                    gap_cnt_d = '0;
                    state_d   = (turnaround > 1) ? StGap : StIdle;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapW'(turnaround - 2)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        link_read  = '0;
        link_write = '0;
        busy       = 1'b0;
        grant_id   = '0;
        grant_wr   = 1'b0;
        unique case (state_q)
            StGrantRd: begin
                link_read[winner_q] = 1'b1;
                busy                = 1'b1;
                grant_id            = winner_q;
            end
            StGrantWr: begin
                link_write[winner_q] = 1'b1;
                busy                 = 1'b1;
                grant_id             = winner_q;
                grant_wr             = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_conv_bus_arbiter.sv
module tb_conv_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rd_req, wr_req;
    logic [3:0] link_read, link_write;
    logic       rvalid, rlast, wready, wuser_last;
    logic       busy;
    logic [1:0] grant_id;
    logic       grant_wr;
`ifdef CONV_ARB_TIMEOUT_EN
    logic       timeout_err;
`endif

    conv_bus_arbiter #(
        .n_units(4),
        .id_width(2),
        .turnaround(1),
        .timeout_cycles(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rd_req(rd_req),
        .wr_req(wr_req),
        .link_read(link_read),
        .link_write(link_write),
        .rvalid(rvalid),
        .rlast(rlast),
        .wready(wready),
        .wuser_last(wuser_last),
        .busy(busy),
        .grant_id(grant_id),
        .grant_wr(grant_wr)
`ifdef CONV_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic       wr;
    } grant_t;

    grant_t exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    bit     check_gap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 20) begin
            tick();
            n++;
        end
        check({name, " grant timeout"}, 32'(busy), 32'd1);
    endtask

    task automatic burst(input bit wr, input int beats);
        for (int b = 0; b < beats; b++) begin
            if (wr) begin
                wready     = 1'b1;
                wuser_last = (b == beats - 1);
            end else begin
                rvalid = 1'b1;
                rlast  = (b == beats - 1);
            end
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; wready = 1'b0; wuser_last = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_req = '0; wr_req = '0;
        rvalid = 1'b0; rlast = 1'b0; wready = 1'b0; wuser_last = 1'b0;
        check_gap = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: one-hot invariant every cycle; grant starts checked against the queue.
    initial begin
        logic   busy_prev = 1'b0;
        int     idle_run  = 0;
        grant_t e;
        forever begin
            @(negedge clk);
            check("onehot", 32'($countones(link_read | link_write) <= 1), 32'd1);
            if (busy && !busy_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected grant", {28'd0, grant_id, 1'b0, grant_wr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    check("grant_wr", 32'(grant_wr), 32'(e.wr));
                    check("link_on", 32'(e.wr ? link_write : link_read), 32'd1 << e.id);
                    check("link_off", 32'(e.wr ? link_read : link_write), 32'd0);
                end
                if (check_gap) check("idle gap", 32'(idle_run), 32'd1);
                idle_run = 0;
            end else if (!busy) begin
                idle_run++;
            end
            busy_prev = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Single read request, latency and release.
        do_reset();
        check("rst link_read", 32'(link_read), 32'd0);
        check("rst link_write", 32'(link_write), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst grant_id", 32'(grant_id), 32'd0);
        check("rst grant_wr", 32'(grant_wr), 32'd0);
        rd_req = 4'b0100;
        exp_q.push_back('{id: 2'd2, wr: 1'b0});
        tick();
        check("t1 latency link_read", 32'(link_read), 32'h4);
        check("t1 latency busy", 32'(busy), 32'd1);
        rd_req = '0;
        tick();
        tick();
        check("t1 hold link_read", 32'(link_read), 32'h4);
        burst(1'b0, 1);
        check("t1 release link_read", 32'(link_read), 32'd0);
        check("t1 release busy", 32'(busy), 32'd0);

        // Round robin with all units requesting continuously.
        do_reset();
        rd_req = 4'b1111;
        exp_q.push_back('{id: 2'd0, wr: 1'b0});
        exp_q.push_back('{id: 2'd1, wr: 1'b0});
        exp_q.push_back('{id: 2'd2, wr: 1'b0});
        exp_q.push_back('{id: 2'd3, wr: 1'b0});
        exp_q.push_back('{id: 2'd0, wr: 1'b0});
        for (int k = 0; k < 5; k++) begin
            wait_busy("t2");
            if (k == 4) rd_req = '0;
            burst(1'b0, 3);
            if (k == 0) check_gap = 1'b1;
        end
        tick();
        check_gap = 1'b0;

        // Write before read inside a unit; read waits for other requesters.
        do_reset();
        wr_req = 4'b0010;
        rd_req = 4'b1010;
        exp_q.push_back('{id: 2'd1, wr: 1'b1});
        exp_q.push_back('{id: 2'd3, wr: 1'b0});
        exp_q.push_back('{id: 2'd1, wr: 1'b0});
        wait_busy("t3 wr");
        wr_req = '0;
        rvalid = 1'b1; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        check("t3 write ignores rlast", {30'd0, busy, grant_wr}, 32'd3);
        burst(1'b1, 2);
        wait_busy("t3 rd3");
        rd_req = 4'b0010;
        burst(1'b0, 1);
        wait_busy("t3 rd1");
        rd_req = '0;
        burst(1'b0, 2);
        tick();

        // Request dropped mid-burst keeps the grant.
        do_reset();
        rd_req = 4'b0001;
        exp_q.push_back('{id: 2'd0, wr: 1'b0});
        wait_busy("t4");
        rd_req = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4 hold after drop", 32'(link_read), 32'h1);
        end
        burst(1'b0, 1);
        check("t4 released", 32'(link_read), 32'd0);

        // Reset in the middle of a write burst clears grant and rr_ptr.
        do_reset();
        wr_req = 4'b0100;
        exp_q.push_back('{id: 2'd2, wr: 1'b1});
        wait_busy("t5 u2");
        wr_req = '0;
        burst(1'b1, 1);
        wr_req = 4'b0001;
        exp_q.push_back('{id: 2'd0, wr: 1'b1});
        wait_busy("t5 u0");
        wr_req = '0;
        wready = 1'b1;
        tick();
        wready = 1'b0;
        rst = 1'b1;
        tick();
        check("t5 rst link_write", 32'(link_write), 32'd0);
        check("t5 rst busy", 32'(busy), 32'd0);
        check("t5 rst grant_id", 32'(grant_id), 32'd0);
        check("t5 rst grant_wr", 32'(grant_wr), 32'd0);
        rst = 1'b0;
        wr_req = 4'b1001;
        exp_q.push_back('{id: 2'd0, wr: 1'b1});
        wait_busy("t5 ptr");
        wr_req = '0;
        burst(1'b1, 1);
        wr_req = 4'b1000;
        exp_q.push_back('{id: 2'd3, wr: 1'b1});
        wait_busy("t5 u3");
        wr_req = '0;
        burst(1'b1, 1);
        tick();

`ifdef CONV_ARB_TIMEOUT_EN
        begin
            int cyc = 0;
            do_reset();
            check("to rst err", 32'(timeout_err), 32'd0);
            rd_req = 4'b0011;
            exp_q.push_back('{id: 2'd0, wr: 1'b0});
            exp_q.push_back('{id: 2'd1, wr: 1'b0});
            wait_busy("to u0");
            while (busy && cyc < 40) begin
                tick();
                cyc++;
            end
            check("to grant length", 32'(cyc), 32'd16);
            check("to err set", 32'(timeout_err), 32'd1);
            wait_busy("to u1");
            rd_req = '0;
            burst(1'b0, 1);
            check("to err sticky", 32'(timeout_err), 32'd1);
            do_reset();
            check("to err cleared", 32'(timeout_err), 32'd0);
        end
`endif

        repeat (4) tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
